eth_rx_pkt_buffer: RTL and testbench

//  Store-and-forward receive buffer between the 100G MAC RX AXI-Stream and the DMA-side stream.

---
 rtl/eth_rx_pkg.sv | 27 ++
 rtl/eth_rx_pkt_buffer_ram.sv | 28 ++
 rtl/eth_rx_pkt_buffer.sv | 231 +++++++++++++++++++++++
 tb/tb_eth_rx_pkt_buffer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and sizing helpers for the Ethernet RX store-and-forward buffer.
package eth_rx_pkg;

    localparam int DEF_DATA_W = 512;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DISCARD
    } wr_state_e;

    // Beat layout at the default stream width; the top re-declares it at its own DATA_W.
    typedef struct packed {
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_DATA_W/8-1:0] keep;
        logic                    last;
    } beat_t;

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/eth_rx_pkt_buffer_ram.sv
// Simple dual-port RAM holding buffered beats; one write port, one read port with 1-cycle registered read.
module eth_rx_pkt_buffer_ram
    import eth_rx_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = ptr_w(DEPTH) - 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_rx_pkt_buffer.sv
// Store-and-forward Ethernet RX buffer: commits only good, legal-length frames and streams them out.
// Optional saturating statistics counters are enabled by defining ETH_RX_PKT_BUFFER_STATS_EN.
module eth_rx_pkt_buffer
    import eth_rx_pkg::*;
#(
    parameter int  DATA_W          = 512,
    parameter int  DEPTH           = 512,
    parameter int  MAX_FRAME_BEATS = 160,
    localparam int KEEP_W          = keep_w(DATA_W),
    localparam int PTR_W           = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_tvalid,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic [KEEP_W-1:0] rx_tkeep,
    input  logic              rx_tuser,
    input  logic              rx_tlast,
    output logic              so_tvalid,
    input  logic              so_tready,
    output logic [DATA_W-1:0] so_tdata,
    output logic [KEEP_W-1:0] so_tkeep,
    output logic              so_tlast,
    output logic [15:0]       frames_stored,
    output logic [PTR_W-1:0]  free_entries
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
    ,
    output logic [31:0]       stat_total,
    output logic [31:0]       stat_corrupt,
    output logic [31:0]       stat_dropped
`endif
);

    localparam int AW     = PTR_W - 1;
    localparam int BEAT_W = DATA_W + KEEP_W + 1;
    localparam int CNT_W  = $clog2(MAX_FRAME_BEATS + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } ram_beat_t;

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_cmt_q, wr_cmt_d, wr_tmp_q, wr_tmp_d;
    logic [PTR_W-1:0] rd_q, rd_d, fetch_q, fetch_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]      frames_q, frames_d;
    logic             out_v_q, out_v_d, skid_v_q, skid_v_d, pend_q, pend_d;
    ram_beat_t        out_q, out_d, skid_q, skid_d;

    logic             full, too_long, wr_en, commit, drop_ovf, drop_bad, tlast_seen;
    logic             pop, fetch_en;
    logic [1:0]       occ;
    ram_beat_t        wr_beat, rd_beat;
    logic [BEAT_W-1:0] ram_rdata;

    assign full       = (wr_tmp_q - rd_q) == PTR_W'(DEPTH);
    assign too_long   = beat_cnt_q == CNT_W'(MAX_FRAME_BEATS);
    assign tlast_seen = rx_tvalid && rx_tlast;
    assign wr_beat    = '{data: rx_tdata, keep: rx_tkeep, last: rx_tlast};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WR_IDLE;
            wr_cmt_q   <= '0;
            wr_tmp_q   <= '0;
            rd_q       <= '0;
            fetch_q    <= '0;
            beat_cnt_q <= '0;
            frames_q   <= '0;
            out_v_q    <= 1'b0;
            skid_v_q   <= 1'b0;
            pend_q     <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_cmt_q   <= wr_cmt_d;
            wr_tmp_q   <= wr_tmp_d;
            rd_q       <= rd_d;
            fetch_q    <= fetch_d;
            beat_cnt_q <= beat_cnt_d;
            frames_q   <= frames_d;
            out_v_q    <= out_v_d;
            skid_v_q   <= skid_v_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WR_IDLE: begin
                if (rx_tvalid && !rx_tlast) state_d = full ? WR_DISCARD : WR_RECV;
            end
            WR_RECV: begin
                if (rx_tvalid) begin
                    if (rx_tlast)              state_d = WR_IDLE;
                    else if (full || too_long) state_d = WR_DISCARD;
                end
            end
            WR_DISCARD: begin
                if (tlast_seen) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // wr_tmp runs ahead of wr_cmt while a frame is in flight; a drop simply snaps it back.
    always_comb begin
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop_ovf   = 1'b0;
        drop_bad   = 1'b0;
        wr_tmp_d   = wr_tmp_q;
        wr_cmt_d   = wr_cmt_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            WR_IDLE, WR_RECV: begin
                if (rx_tvalid) begin
                    if (full || (state_q == WR_RECV && too_long)) begin
                        drop_ovf = 1'b1;
                        wr_tmp_d = wr_cmt_q;
                    end else begin
                        wr_en = 1'b1;
                        if (!rx_tlast) begin
                            wr_tmp_d   = wr_tmp_q + PTR_W'(1);
                            beat_cnt_d = (state_q == WR_IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
                        end else if (rx_tuser) begin
                            drop_bad = 1'b1;
                            wr_tmp_d = wr_cmt_q;
                        end else begin
                            commit   = 1'b1;
                            wr_tmp_d = wr_tmp_q + PTR_W'(1);
                            wr_cmt_d = wr_tmp_q + PTR_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Output register plus skid entry; reads are issued only while both can absorb them.
    assign pop      = out_v_q && so_tready;
    assign occ      = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q) - 2'(pop);
    assign fetch_en = (fetch_q != wr_cmt_q) && (occ < 2'd2);
    assign rd_beat  = ram_rdata;

    always_comb begin
        out_v_d  = out_v_q;
        out_d    = out_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (pop) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                skid_v_d = pend_q;
                if (pend_q) skid_d = rd_beat;
            end else begin
                out_v_d = pend_q;
                if (pend_q) out_d = rd_beat;
            end
        end else if (pend_q) begin
            if (!out_v_q) begin
                out_v_d = 1'b1;
                out_d   = rd_beat;
            end else begin
                skid_v_d = 1'b1;
                skid_d   = rd_beat;
            end
        end
    end

    always_comb begin
        pend_d   = fetch_en;
        fetch_d  = fetch_q + PTR_W'(fetch_en);
        rd_d     = rd_q + PTR_W'(pop);
        frames_d = frames_q + 16'(commit) - 16'(pop && out_q.last);
    end

    eth_rx_pkt_buffer_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_tmp_q[AW-1:0]),
        .wr_data (wr_beat),
        .rd_en   (fetch_en),
        .rd_addr (fetch_q[AW-1:0]),
        .rd_data (ram_rdata)
    );

    assign so_tvalid     = out_v_q;
    assign so_tdata      = out_q.data;
    assign so_tkeep      = out_q.keep;
    assign so_tlast      = out_q.last;
    assign frames_stored = frames_q;
    assign free_entries  = PTR_W'(DEPTH) - (wr_tmp_q - rd_q);

`ifdef ETH_RX_PKT_BUFFER_STATS_EN
    logic [31:0] total_q, total_d, corrupt_q, corrupt_d, dropped_q, dropped_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q   <= '0;
            corrupt_q <= '0;
            dropped_q <= '0;
        end else begin
            total_q   <= total_d;
            corrupt_q <= corrupt_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        total_d   = total_q + 32'(tlast_seen && (total_q != '1));
        corrupt_d = corrupt_q + 32'(drop_bad && (corrupt_q != '1));
        dropped_d = dropped_q + 32'(drop_ovf && (dropped_q != '1));
    end

    assign stat_total   = total_q;
    assign stat_corrupt = corrupt_q;
    assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_eth_rx_pkt_buffer.sv
// Directed self-checking bench for eth_rx_pkt_buffer (DATA_W=64, DEPTH=16, MAX_FRAME_BEATS=8).
// Statistics checks are active when ETH_RX_PKT_BUFFER_STATS_EN is defined.
module tb_eth_rx_pkt_buffer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int MAXB   = 8;
    localparam int KEEP_W = 8;
    localparam int BW     = DATA_W + KEEP_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_tvalid = 1'b0;
    logic [DATA_W-1:0] rx_tdata = '0;
    logic [KEEP_W-1:0] rx_tkeep = '0;
    logic              rx_tuser = 1'b0;
    logic              rx_tlast = 1'b0;
    logic              so_tvalid;
    logic              so_tready = 1'b0;
    logic [DATA_W-1:0] so_tdata;
    logic [KEEP_W-1:0] so_tkeep;
    logic              so_tlast;
    logic [15:0]       frames_stored;
    logic [4:0]        free_entries;
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
    logic [31:0]       stat_total, stat_corrupt, stat_dropped;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int unstable_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_out = '0;
    logic [BW-1:0] got_q [$];
    logic [BW-1:0] exp_q [$];

    eth_rx_pkt_buffer #(
        .DATA_W          (DATA_W),
        .DEPTH           (DEPTH),
        .MAX_FRAME_BEATS (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_tvalid     (rx_tvalid),
        .rx_tdata      (rx_tdata),
        .rx_tkeep      (rx_tkeep),
        .rx_tuser      (rx_tuser),
        .rx_tlast      (rx_tlast),
        .so_tvalid     (so_tvalid),
        .so_tready     (so_tready),
        .so_tdata      (so_tdata),
        .so_tkeep      (so_tkeep),
        .so_tlast      (so_tlast),
        .frames_stored (frames_stored),
        .free_entries  (free_entries)
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        ,
        .stat_total    (stat_total),
        .stat_corrupt  (stat_corrupt),
        .stat_dropped  (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    // Record accepted output beats and flag any change of a stalled output beat.
    always @(negedge clk) begin
        if (so_tvalid && so_tready) got_q.push_back({so_tlast, so_tkeep, so_tdata});
        if (prev_stall && (!so_tvalid || ({so_tlast, so_tkeep, so_tdata} !== prev_out)))
            unstable_cnt++;
        prev_stall = so_tvalid && !so_tready;
        prev_out   = {so_tlast, so_tkeep, so_tdata};
    end

    function automatic logic [DATA_W-1:0] mk_data(input int id, input int b);
        return {8'hA5, 24'(id), 8'h5A, 24'(b)};
    endfunction

    task automatic send_frame(input int id, input int n, input bit bad, input bit expect_out);
        for (int b = 0; b < n; b++) begin
            @(posedge clk); #1;
            rx_tvalid = 1'b1;
            rx_tdata  = mk_data(id, b);
            rx_tlast  = (b == n - 1);
            rx_tkeep  = rx_tlast ? 8'h0F : 8'hFF;
            rx_tuser  = bad && rx_tlast;
            if (expect_out) exp_q.push_back({rx_tlast, rx_tkeep, rx_tdata});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_tvalid = 1'b0;
            rx_tlast  = 1'b0;
            rx_tuser  = 1'b0;
        end
    endtask

    task automatic do_reset(input bit ready);
        @(posedge clk); #1;
        rst = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0; so_tready = ready;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({so_tvalid, so_tlast} !== 2'b00) begin
            tests_failed++; $display("[TB] FAIL reset_valid_last: got %b expected 00", {so_tvalid, so_tlast});
        end
        tests_run++;
        if ({so_tkeep, so_tdata} !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", {so_tkeep, so_tdata});
        end
        tests_run++;
        if (frames_stored !== 16'd0) begin
            tests_failed++; $display("[TB] FAIL reset_frames: got %0d expected 0", frames_stored);
        end
        tests_run++;
        if (free_entries !== 5'd16) begin
            tests_failed++; $display("[TB] FAIL reset_free: got %0d expected 16", free_entries);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if ({stat_total, stat_corrupt, stat_dropped} !== 96'd0) begin
            tests_failed++; $display("[TB] FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", stat_total, stat_corrupt, stat_dropped);
        end
`endif
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_good_frame();
        int gb, eb;
        logic [BW-1:0] g;
        do_reset(1'b1);
        gb = got_q.size(); eb = exp_q.size();
        send_frame(1, 3, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        tests_run++;
        if (frames_stored !== 16'd1 || so_tvalid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL good_commit: frames %0d valid %b expected 1 0", frames_stored, so_tvalid);
        end
        tests_run++;
        if (free_entries !== 5'd13) begin
            tests_failed++; $display("[TB] FAIL good_free_after_commit: got %0d expected 13", free_entries);
        end
        @(negedge clk);
        tests_run++;
        if (so_tvalid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL good_latency_early: so_tvalid got %b expected 0", so_tvalid);
        end
        @(negedge clk);
        tests_run++;
        if (so_tvalid !== 1'b1 || {so_tlast, so_tkeep, so_tdata} !== exp_q[eb]) begin
            tests_failed++; $display("[TB] FAIL good_latency: valid %b beat %h expected 1 %h", so_tvalid, {so_tlast, so_tkeep, so_tdata}, exp_q[eb]);
        end
        idle(6);
        tests_run++;
        if (got_q.size() - gb != 3) begin
            tests_failed++; $display("[TB] FAIL good_count: got %0d beats expected 3", got_q.size() - gb);
        end
        for (int i = 0; i < 3; i++) begin
            g = (gb + i < got_q.size()) ? got_q[gb + i] : 'x;
            tests_run++;
            if (g !== exp_q[eb + i]) begin
                tests_failed++; $display("[TB] FAIL good_beat%0d: got %h expected %h", i, g, exp_q[eb + i]);
            end
        end
        tests_run++;
        if (frames_stored !== 16'd0 || free_entries !== 5'd16) begin
            tests_failed++; $display("[TB] FAIL good_drain: frames %0d free %0d expected 0 16", frames_stored, free_entries);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if (stat_total !== 32'd1) begin
            tests_failed++; $display("[TB] FAIL good_total: got %0d expected 1", stat_total);
        end
`endif
    endtask

    task automatic test_corrupt();
        int gb;
        do_reset(1'b1);
        gb = got_q.size();
        send_frame(2, 4, 1'b1, 1'b0);
        idle(6);
        tests_run++;
        if (got_q.size() != gb) begin
            tests_failed++; $display("[TB] FAIL corrupt_no_output: got %0d beats expected 0", got_q.size() - gb);
        end
        tests_run++;
        if (free_entries !== 5'd16 || frames_stored !== 16'd0) begin
            tests_failed++; $display("[TB] FAIL corrupt_rollback: free %0d frames %0d expected 16 0", free_entries, frames_stored);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if (stat_corrupt !== 32'd1 || stat_total !== 32'd1 || stat_dropped !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL corrupt_stats: got %0d/%0d/%0d expected 1/1/0", stat_total, stat_corrupt, stat_dropped);
        end
`endif
    endtask

    task automatic test_oversize();
        int gb, eb;
        logic [BW-1:0] g;
        do_reset(1'b1);
        gb = got_q.size(); eb = exp_q.size();
        send_frame(3, 9, 1'b0, 1'b0);
        send_frame(4, 2, 1'b0, 1'b1);
        send_frame(5, MAXB, 1'b0, 1'b1);
        idle(12);
        tests_run++;
        if (got_q.size() - gb != 2 + MAXB) begin
            tests_failed++; $display("[TB] FAIL oversize_count: got %0d beats expected %0d", got_q.size() - gb, 2 + MAXB);
        end
        for (int i = 0; i < 2 + MAXB; i++) begin
            g = (gb + i < got_q.size()) ? got_q[gb + i] : 'x;
            tests_run++;
            if (g !== exp_q[eb + i]) begin
                tests_failed++; $display("[TB] FAIL oversize_beat%0d: got %h expected %h", i, g, exp_q[eb + i]);
            end
        end
        tests_run++;
        if (free_entries !== 5'd16 || frames_stored !== 16'd0) begin
            tests_failed++; $display("[TB] FAIL oversize_drain: free %0d frames %0d expected 16 0", free_entries, frames_stored);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if (stat_dropped !== 32'd1 || stat_total !== 32'd3 || stat_corrupt !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL oversize_stats: got %0d/%0d/%0d expected 3/0/1", stat_total, stat_corrupt, stat_dropped);
        end
`endif
    endtask

    task automatic test_overflow();
        int gb, eb, ub, bubbles;
        logic [BW-1:0] g;
        do_reset(1'b0);
        gb = got_q.size(); eb = exp_q.size(); ub = unstable_cnt; bubbles = 0;
        for (int f = 0; f < 4; f++) send_frame(10 + f, 4, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        tests_run++;
        if (free_entries !== 5'd0 || frames_stored !== 16'd4) begin
            tests_failed++; $display("[TB] FAIL overflow_full: free %0d frames %0d expected 0 4", free_entries, frames_stored);
        end
        tests_run++;
        if (so_tvalid !== 1'b1 || {so_tlast, so_tkeep, so_tdata} !== exp_q[eb]) begin
            tests_failed++; $display("[TB] FAIL overflow_head: valid %b beat %h expected 1 %h", so_tvalid, {so_tlast, so_tkeep, so_tdata}, exp_q[eb]);
        end
        send_frame(14, 4, 1'b0, 1'b0);
        idle(3);
        tests_run++;
        if (free_entries !== 5'd0 || frames_stored !== 16'd4 || got_q.size() != gb) begin
            tests_failed++; $display("[TB] FAIL overflow_drop: free %0d frames %0d beats %0d expected 0 4 0", free_entries, frames_stored, got_q.size() - gb);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if (stat_dropped !== 32'd1 || stat_total !== 32'd5) begin
            tests_failed++; $display("[TB] FAIL overflow_stats: total %0d dropped %0d expected 5 1", stat_total, stat_dropped);
        end
`endif
        @(posedge clk); #1 so_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (so_tvalid !== 1'b1) bubbles++;
        end
        idle(3);
        tests_run++;
        if (bubbles != 0) begin
            tests_failed++; $display("[TB] FAIL overflow_bubbles: got %0d expected 0", bubbles);
        end
        tests_run++;
        if (got_q.size() - gb != 16) begin
            tests_failed++; $display("[TB] FAIL overflow_count: got %0d beats expected 16", got_q.size() - gb);
        end
        for (int i = 0; i < 16; i++) begin
            g = (gb + i < got_q.size()) ? got_q[gb + i] : 'x;
            tests_run++;
            if (g !== exp_q[eb + i]) begin
                tests_failed++; $display("[TB] FAIL overflow_beat%0d: got %h expected %h", i, g, exp_q[eb + i]);
            end
        end
        tests_run++;
        if (unstable_cnt != ub) begin
            tests_failed++; $display("[TB] FAIL overflow_stable: got %0d changes while stalled expected 0", unstable_cnt - ub);
        end
        tests_run++;
        if (free_entries !== 5'd16 || frames_stored !== 16'd0) begin
            tests_failed++; $display("[TB] FAIL overflow_drain: free %0d frames %0d expected 16 0", free_entries, frames_stored);
        end
    endtask

    task automatic test_back_to_back();
        int gb, eb;
        logic [BW-1:0] g;
        do_reset(1'b1);
        gb = got_q.size(); eb = exp_q.size();
        for (int f = 0; f < 20; f++) send_frame(20 + f, 1, 1'b0, 1'b1);
        idle(8);
        tests_run++;
        if (got_q.size() - gb != 20) begin
            tests_failed++; $display("[TB] FAIL b2b_count: got %0d beats expected 20", got_q.size() - gb);
        end
        for (int i = 0; i < 20; i++) begin
            g = (gb + i < got_q.size()) ? got_q[gb + i] : 'x;
            tests_run++;
            if (g !== exp_q[eb + i]) begin
                tests_failed++; $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, g, exp_q[eb + i]);
            end
        end
        tests_run++;
        if (frames_stored !== 16'd0) begin
            tests_failed++; $display("[TB] FAIL b2b_frames: got %0d expected 0", frames_stored);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if (stat_total !== 32'd20) begin
            tests_failed++; $display("[TB] FAIL b2b_total: got %0d expected 20", stat_total);
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        int gb, eb;
        logic [BW-1:0] g;
        do_reset(1'b0);
        send_frame(30, 2, 1'b0, 1'b0);
        send_frame(31, 2, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            rx_tvalid = 1'b1; rx_tdata = mk_data(32, b); rx_tkeep = 8'hFF; rx_tlast = 1'b0; rx_tuser = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1; rx_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({so_tvalid, so_tlast} !== 2'b00 || {so_tkeep, so_tdata} !== '0) begin
            tests_failed++; $display("[TB] FAIL rstmid_outputs: valid %b last %b beat %h expected 0 0 0", so_tvalid, so_tlast, {so_tkeep, so_tdata});
        end
        tests_run++;
        if (frames_stored !== 16'd0 || free_entries !== 5'd16) begin
            tests_failed++; $display("[TB] FAIL rstmid_status: frames %0d free %0d expected 0 16", frames_stored, free_entries);
        end
`ifdef ETH_RX_PKT_BUFFER_STATS_EN
        tests_run++;
        if ({stat_total, stat_corrupt, stat_dropped} !== 96'd0) begin
            tests_failed++; $display("[TB] FAIL rstmid_stats: got %0d/%0d/%0d expected 0/0/0", stat_total, stat_corrupt, stat_dropped);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0; so_tready = 1'b1;
        gb = got_q.size(); eb = exp_q.size();
        send_frame(40, 2, 1'b0, 1'b1);
        idle(8);
        tests_run++;
        if (got_q.size() - gb != 2) begin
            tests_failed++; $display("[TB] FAIL rstmid_count: got %0d beats expected 2", got_q.size() - gb);
        end
        for (int i = 0; i < 2; i++) begin
            g = (gb + i < got_q.size()) ? got_q[gb + i] : 'x;
            tests_run++;
            if (g !== exp_q[eb + i]) begin
                tests_failed++; $display("[TB] FAIL rstmid_beat%0d: got %h expected %h", i, g, exp_q[eb + i]);
            end
        end
        tests_run++;
        if (frames_stored !== 16'd0 || free_entries !== 5'd16) begin
            tests_failed++; $display("[TB] FAIL rstmid_drain: frames %0d free %0d expected 0 16", frames_stored, free_entries);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_corrupt();
        test_oversize();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
